// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer and the PC increment register.
// Holds the PC command encoding (also decoded by the PC register) and the fetch state encoding.
// No logic; types and constants only.
package fetch_sequencer_pkg;

  // PC register commands; the sibling PC register decodes the same values
  localparam logic [1:0] PC_HOLD  = 2'b00;
  localparam logic [1:0] PC_LOAD  = 2'b01;
  localparam logic [1:0] PC_INCR  = 2'b10;
  localparam logic [1:0] PC_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT    = 2'b00,
    ST_FETCH   = 2'b01,
    ST_FLUSH   = 2'b10,
    ST_DELIVER = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the PC register, issues reads at the PC, hands words to the decoder.
// Latency: ir_valid rises at the edge where mem_ack is sampled (1 cycle minimum after entering FETCH).
// Backpressure: holds the instruction in DELIVER until ir_ready; mem_req is held until mem_ack.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] pc,
  output logic [1:0]   pc_ctrl,
  output logic [N-1:0] pc_load,
  output logic         mem_req,
  output logic [N-1:0] mem_addr,
  input  logic         mem_ack,
  input  logic [W-1:0] mem_rdata,
  output logic         ir_valid,
  output logic [W-1:0] ir,
  output logic [N-1:0] ir_pc,
  input  logic         ir_ready,
  input  logic         redirect,
  input  logic [N-1:0] redirect_addr
);

  fetch_state_e state_q;
  logic [N-1:0] addr_q;     // address of the request currently on the bus
  logic [W-1:0] ir_q;
  logic [N-1:0] ir_pc_q;
  logic         ir_valid_q;

  assign pc_load  = redirect_addr;
  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;

  // PC command and memory request decode from current state and inputs
  always_comb begin
    pc_ctrl  = PC_HOLD;
    mem_req  = 1'b0;
    mem_addr = addr_q;
    case (state_q)
      ST_INIT: begin
        pc_ctrl = redirect ? PC_LOAD : PC_CLEAR;
      end
      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (redirect) pc_ctrl = PC_LOAD;
      end
      ST_FLUSH: begin
        // wrong-path request stays on the bus at its original address until acked;
        // a further redirect simply reloads the PC so the latest target wins
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (redirect) pc_ctrl = PC_LOAD;
      end
      ST_DELIVER: begin
        if (redirect)      pc_ctrl = PC_LOAD;
        else if (ir_ready) pc_ctrl = PC_INCR;
      end
      default: begin
        pc_ctrl = PC_CLEAR;
      end
    endcase
  end

  // State transitions and instruction register capture
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_INIT;
      addr_q     <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          addr_q <= pc;
          if (mem_ack && !redirect) begin
            ir_q       <= mem_rdata;
            ir_pc_q    <= pc;
            ir_valid_q <= 1'b1;
            state_q    <= ST_DELIVER;
          end else if (mem_ack) begin
            // response belongs to the old path; refetch at the new PC next cycle
            state_q <= ST_FETCH;
          end else if (redirect) begin
            state_q <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (mem_ack) state_q <= ST_FETCH;
        end
        ST_DELIVER: begin
          // redirect drops the instruction even when the decoder is ready
          if (redirect || ir_ready) begin
            ir_valid_q <= 1'b0;
            state_q    <= ST_FETCH;
          end
        end
        default: begin
          state_q <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: PC register and variable-latency memory models around the DUT,
// a transaction-level reference checked every cycle, plus directed literal expectations.
// Inputs change 1ns after the rising edge; everything is sampled on the falling edge.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  pc;
  logic [1:0]  pc_ctrl;
  logic [7:0]  pc_load;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        ir_valid;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_ready;
  logic        redirect;
  logic [7:0]  redirect_addr;

  int checks   = 0;
  int failures = 0;

  // memory model: ack after lat extra cycles of held request, data = 0x1000 + addr
  int lat;
  int mem_cnt;

  always #5 clk = ~clk;

  fetch_sequencer #(.N(8), .W(16)) dut (
    .clk(clk), .clr(clr), .pc(pc), .pc_ctrl(pc_ctrl), .pc_load(pc_load),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .ir_ready(ir_ready),
    .redirect(redirect), .redirect_addr(redirect_addr)
  );

  // sibling PC increment register
  always @(posedge clk or posedge clr) begin
    if (clr) pc <= 8'h00;
    else begin
      case (pc_ctrl)
        2'b01:   pc <= pc_load;
        2'b10:   pc <= pc + 8'd1;
        2'b11:   pc <= 8'h00;
        default: pc <= pc;
      endcase
    end
  end

  assign mem_ack   = mem_req && (mem_cnt == lat);
  assign mem_rdata = 16'h1000 + {8'h00, mem_addr};

  always @(posedge clk or posedge clr) begin
    if (clr) mem_cnt <= 0;
    else if (mem_req && !mem_ack) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // started: first post-reset cycle has passed; has_instr: an instruction awaits the decoder;
  // wrong_path: the outstanding request was overtaken by a redirect and its data must be dropped.
  bit          m_started, m_has_instr, m_wrong_path;
  logic [7:0]  m_stale, m_instr_pc;
  logic [15:0] m_instr;

  always @(negedge clk) begin
    logic [1:0] e_ctrl;
    if (clr) begin
      m_started = 0; m_has_instr = 0; m_wrong_path = 0;
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_pc_ctrl", {30'd0, pc_ctrl}, 32'd3);
      chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    end else begin
      if (!m_started) begin
        e_ctrl = redirect ? 2'b01 : 2'b11;
        chk("m_mem_req", {31'd0, mem_req}, 32'd0);
      end else if (m_has_instr) begin
        e_ctrl = redirect ? 2'b01 : (ir_ready ? 2'b10 : 2'b00);
        chk("m_mem_req", {31'd0, mem_req}, 32'd0);
        chk("m_ir", {16'd0, ir}, {16'd0, m_instr});
        chk("m_ir_pc", {24'd0, ir_pc}, {24'd0, m_instr_pc});
      end else begin
        e_ctrl = redirect ? 2'b01 : 2'b00;
        chk("m_mem_req", {31'd0, mem_req}, 32'd1);
        chk("m_mem_addr", {24'd0, mem_addr}, {24'd0, (m_wrong_path ? m_stale : pc)});
      end
      chk("m_pc_ctrl", {30'd0, pc_ctrl}, {30'd0, e_ctrl});
      chk("m_pc_load", {24'd0, pc_load}, {24'd0, redirect_addr});
      chk("m_ir_valid", {31'd0, ir_valid}, {31'd0, m_has_instr});
      // advance to what the next edge must produce
      if (!m_started) m_started = 1;
      else if (m_has_instr) begin
        if (redirect || ir_ready) m_has_instr = 0;
      end else if (mem_ack) begin
        if (!m_wrong_path && !redirect) begin
          m_has_instr = 1; m_instr = mem_rdata; m_instr_pc = pc;
        end
        m_wrong_path = 0;
      end else if (redirect && !m_wrong_path) begin
        m_wrong_path = 1; m_stale = pc;
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask
  task automatic sample;
    @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    clr = 1'b1; lat = 0; ir_ready = 1'b1; redirect = 1'b0; redirect_addr = 8'h00;
    sample;
    chk("rst_ir", {16'd0, ir}, 32'd0);
    chk("rst_ir_pc", {24'd0, ir_pc}, 32'd0);
    tick; clr = 1'b0;
    // cycle 0: INIT
    sample;
    chk("init_pc_ctrl", {30'd0, pc_ctrl}, 32'd3);
    chk("init_mem_req", {31'd0, mem_req}, 32'd0);
    // single-cycle memory, decoder always ready: one instruction per two cycles
    for (int k = 0; k < 3; k++) begin
      tick; sample;
      chk("seq_mem_addr", {24'd0, mem_addr}, k);
      chk("seq_fetch_valid", {31'd0, ir_valid}, 32'd0);
      tick; sample;
      chk("seq_valid", {31'd0, ir_valid}, 32'd1);
      chk("seq_ir", {16'd0, ir}, 32'h1000 + k);
      chk("seq_ir_pc", {24'd0, ir_pc}, k);
      chk("seq_pc_ctrl", {30'd0, pc_ctrl}, 32'd2);
    end
    // decoder stalls for 5 cycles
    tick; ir_ready = 1'b0; sample;
    chk("stall_fetch_addr", {24'd0, mem_addr}, 32'd3);
    for (int i = 0; i < 5; i++) begin
      tick; sample;
      chk("stall_ir", {16'd0, ir}, 32'h1003);
      chk("stall_ir_pc", {24'd0, ir_pc}, 32'd3);
      chk("stall_mem_req", {31'd0, mem_req}, 32'd0);
      chk("stall_pc_ctrl", {30'd0, pc_ctrl}, 32'd0);
    end
    tick; ir_ready = 1'b1; sample;
    chk("stall_release_ctrl", {30'd0, pc_ctrl}, 32'd2);
    tick; sample;
    chk("after_stall_addr", {24'd0, mem_addr}, 32'd4);
    // redirect to 0x40 while delivering with ready high
    tick; redirect = 1'b1; redirect_addr = 8'h40; sample;
    chk("redir_ir", {16'd0, ir}, 32'h1004);
    chk("redir_pc_ctrl", {30'd0, pc_ctrl}, 32'd1);
    chk("redir_pc_load", {24'd0, pc_load}, 32'h40);
    tick; redirect = 1'b0; sample;
    chk("redir_dropped", {31'd0, ir_valid}, 32'd0);
    chk("redir_addr", {24'd0, mem_addr}, 32'h40);
    tick; sample;
    chk("redir_ir_new", {16'd0, ir}, 32'h1040);
    // 3-cycle memory delay, redirect to 0x80 in first FETCH cycle
    tick; lat = 3; redirect = 1'b1; redirect_addr = 8'h80; sample;
    chk("flush_first_addr", {24'd0, mem_addr}, 32'h41);
    chk("flush_first_ctrl", {30'd0, pc_ctrl}, 32'd1);
    tick; redirect = 1'b0; sample;
    chk("flush_hold_addr", {24'd0, mem_addr}, 32'h41);
    chk("flush_hold_req", {31'd0, mem_req}, 32'd1);
    tick; sample;
    chk("flush_hold_addr2", {24'd0, mem_addr}, 32'h41);
    tick; sample;
    chk("flush_ack", {31'd0, mem_ack}, 32'd1);
    chk("flush_ack_addr", {24'd0, mem_addr}, 32'h41);
    tick; sample;
    chk("flush_discard", {31'd0, ir_valid}, 32'd0);
    chk("flush_new_addr", {24'd0, mem_addr}, 32'h80);
    for (int i = 0; i < 3; i++) begin
      tick; sample;
      chk("slow_wait_addr", {24'd0, mem_addr}, 32'h80);
      chk("slow_wait_valid", {31'd0, ir_valid}, 32'd0);
    end
    tick; lat = 0; sample;
    chk("slow_ir", {16'd0, ir}, 32'h1080);
    chk("slow_ir_pc", {24'd0, ir_pc}, 32'h80);
    // same-cycle ack + redirect discards, then PC wrap from 0xFF
    tick; redirect = 1'b1; redirect_addr = 8'hFF; sample;
    chk("ackredir_ack", {31'd0, mem_ack}, 32'd1);
    chk("ackredir_ctrl", {30'd0, pc_ctrl}, 32'd1);
    tick; redirect = 1'b0; sample;
    chk("ackredir_valid", {31'd0, ir_valid}, 32'd0);
    chk("wrap_fetch_addr", {24'd0, mem_addr}, 32'hFF);
    tick; sample;
    chk("wrap_ir", {16'd0, ir}, 32'h10FF);
    chk("wrap_ctrl", {30'd0, pc_ctrl}, 32'd2);
    tick; sample;
    chk("wrap_next_addr", {24'd0, mem_addr}, 32'h00);
    tick; sample;
    chk("wrap_ir_pc", {24'd0, ir_pc}, 32'h00);
    // reset pulsed while in FLUSH
    tick; lat = 3; redirect = 1'b1; redirect_addr = 8'h20; sample;
    chk("pre_flush_addr", {24'd0, mem_addr}, 32'h01);
    tick; redirect = 1'b0; sample;
    chk("in_flush_req", {31'd0, mem_req}, 32'd1);
    tick; clr = 1'b1; sample;
    chk("clr_req", {31'd0, mem_req}, 32'd0);
    chk("clr_ctrl", {30'd0, pc_ctrl}, 32'd3);
    tick; clr = 1'b0; lat = 0; sample;
    chk("restart_init_ctrl", {30'd0, pc_ctrl}, 32'd3);
    chk("restart_init_req", {31'd0, mem_req}, 32'd0);
    tick; sample;
    chk("restart_addr", {24'd0, mem_addr}, 32'h00);
    chk("restart_req", {31'd0, mem_req}, 32'd1);
    tick; sample;
    chk("restart_ir", {16'd0, ir}, 32'h1000);
    chk("restart_valid", {31'd0, ir_valid}, 32'd1);
    tick; sample;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
